// File: rtl/line_buffer_ctrl_if.sv
// Line-buffer controller bus: video timing in, buffer control out.
// master drives sync/enable, slave is the controller.
interface line_buffer_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              I_VSYNC;
  logic              I_DE;
  logic              O_WR_EN;
  logic [1:0]        O_WR_SEL;
  logic [ADDR_W-1:0] O_ADDR;
  logic [1:0]        O_TOP_SEL;
  logic [1:0]        O_MID_SEL;
  logic              O_WIN_VALID;
  logic              O_FRAME_START;
  logic              O_LINE_END;
  logic              O_ERR_OVF;

  modport master (
    output I_VSYNC, I_DE,
    input  O_WR_EN, O_WR_SEL, O_ADDR,
    input  O_TOP_SEL, O_MID_SEL, O_WIN_VALID,
    input  O_FRAME_START, O_LINE_END, O_ERR_OVF
  );

  modport slave (
    input  I_VSYNC, I_DE,
    output O_WR_EN, O_WR_SEL, O_ADDR,
    output O_TOP_SEL, O_MID_SEL, O_WIN_VALID,
    output O_FRAME_START, O_LINE_END, O_ERR_OVF
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Three-line buffer write/rotation controller for a 3x3 window.
// LBC_OVF_DETECT_EN: flag and drop pixels past IMG_WIDTH (else wrap).
module line_buffer_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_W     = 10
) (
  input  logic              I_PCLK,
  input  logic              I_RST,
  line_buffer_ctrl_if.slave bus
);
  localparam int CW = ADDR_W + 1;
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t            state, state_n;
  logic              vs_q, de_q;
  logic [CW-1:0]     col, col_n, wcol;
  logic [RW-1:0]     row, row_n;
  logic [1:0]        wr_sel, wr_sel_n;
  logic [1:0]        top_q, top_n;
  logic [1:0]        mid_q, mid_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              wr_en_q, wr_en_n;
  logic              win_q, win_n;
  logic              fs_q, fs_n;
  logic              le_q, le_n;
  logic              ovf_q, ovf_n;
  logic              frame_start, line_end, active;

  assign frame_start = bus.I_VSYNC & ~vs_q;
  assign line_end    = ~bus.I_DE & de_q;
  assign active      = (state != IDLE);

  // FSM state register
  always_ff @(posedge I_PCLK or posedge I_RST) begin
    if (I_RST) state <= IDLE;
    else       state <= state_n;
  end

  // next state, counters and output values
  always_comb begin
    state_n  = state;
    col_n    = col;
    row_n    = row;
    wr_sel_n = wr_sel;
    addr_n   = addr_q;
    wr_en_n  = 1'b0;
    win_n    = 1'b0;
    fs_n     = 1'b0;
    le_n     = 1'b0;
    ovf_n    = ovf_q;
    wcol     = col;
    if (frame_start) begin
      state_n  = FILL;
      col_n    = '0;
      row_n    = '0;
      wr_sel_n = 2'd0;
      ovf_n    = 1'b0;
      fs_n     = 1'b1;
      wcol     = '0;
    end else if (active && line_end) begin
      le_n     = 1'b1;
      col_n    = '0;
      wr_sel_n = (wr_sel == 2'd2) ? 2'd0 : wr_sel + 2'd1;
      if (row != ROW_MAX) row_n = row + RW'(1);
      if (state == FILL && row_n == RW'(2)) state_n = RUN;
    end
    if ((frame_start || active) && bus.I_DE) begin
`ifdef LBC_OVF_DETECT_EN
      if (wcol == COL_MAX) begin
        ovf_n = 1'b1;
      end else begin
        wr_en_n = 1'b1;
        addr_n  = wcol[ADDR_W-1:0];
        col_n   = wcol + CW'(1);
        win_n   = (state == RUN) && !frame_start
                  && (wcol >= CW'(2));
      end
`else
      wr_en_n = 1'b1;
      addr_n  = wcol[ADDR_W-1:0];
      col_n   = (wcol >= COL_MAX - CW'(1)) ? '0 : wcol + CW'(1);
      win_n   = (state == RUN) && !frame_start
                && (wcol >= CW'(2));
`endif
    end
`ifndef LBC_OVF_DETECT_EN
    ovf_n = 1'b0;
`endif
    unique case (wr_sel_n)
      2'd0: begin top_n = 2'd1; mid_n = 2'd2; end
      2'd1: begin top_n = 2'd2; mid_n = 2'd0; end
      default: begin top_n = 2'd0; mid_n = 2'd1; end
    endcase
  end

  // edge-detect registers, counters and registered outputs
  always_ff @(posedge I_PCLK or posedge I_RST) begin
    if (I_RST) begin
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      col     <= '0;
      row     <= '0;
      wr_sel  <= 2'd0;
      top_q   <= 2'd1;
      mid_q   <= 2'd2;
      addr_q  <= '0;
      wr_en_q <= 1'b0;
      win_q   <= 1'b0;
      fs_q    <= 1'b0;
      le_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      vs_q    <= bus.I_VSYNC;
      de_q    <= bus.I_DE;
      col     <= col_n;
      row     <= row_n;
      wr_sel  <= wr_sel_n;
      top_q   <= top_n;
      mid_q   <= mid_n;
      addr_q  <= addr_n;
      wr_en_q <= wr_en_n;
      win_q   <= win_n;
      fs_q    <= fs_n;
      le_q    <= le_n;
      ovf_q   <= ovf_n;
    end
  end

  assign bus.O_WR_EN       = wr_en_q;
  assign bus.O_WR_SEL      = wr_sel;
  assign bus.O_ADDR        = addr_q;
  assign bus.O_TOP_SEL     = top_q;
  assign bus.O_MID_SEL     = mid_q;
  assign bus.O_WIN_VALID   = win_q;
  assign bus.O_FRAME_START = fs_q;
  assign bus.O_LINE_END    = le_q;
  assign bus.O_ERR_OVF     = ovf_q;
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: a 640-wide instance for frame-level
// sequences and a 4x4 instance driven from a vector table.
module tb_line_buffer_ctrl;
`ifdef LBC_OVF_DETECT_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_buffer_ctrl_if #(.ADDR_W(10)) bb ();
  line_buffer_ctrl_if #(.ADDR_W(2))  sb ();

  line_buffer_ctrl dut_b (
    .I_PCLK (clk),
    .I_RST  (rst),
    .bus    (bb.slave)
  );

  line_buffer_ctrl #(
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (4),
    .ADDR_W     (2)
  ) dut_s (
    .I_PCLK (clk),
    .I_RST  (rst),
    .bus    (sb.slave)
  );

  typedef struct {
    logic       vs;
    logic       de;
    logic       wr;
    logic [3:0] addr;
    logic [1:0] sel;
    logic       win;
    logic       fs;
    logic       le;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic db(input logic vs, input logic de);
    bb.I_VSYNC = vs;
    bb.I_DE    = de;
  endtask

  task automatic add(input logic vs, input logic de, input logic wr,
                     input int addr, input int sel, input logic win,
                     input logic fs, input logic le, input logic ovf);
    vec_t v;
    v.vs = vs; v.de = de; v.wr = wr;
    v.addr = 4'(addr); v.sel = 2'(sel);
    v.win = win; v.fs = fs; v.le = le; v.ovf = ovf;
    tbl.push_back(v);
  endtask

  task automatic px(input int a, input int sel, input logic win);
    add(0, 1, 1, a, sel, win, 0, 0, 0);
  endtask

  task automatic le(input int sel, input logic ovf);
    add(0, 0, 0, 0, sel, 0, 0, 1, ovf);
  endtask

  function automatic bit rst_bad();
    return bb.O_WR_EN !== 1'b0 || bb.O_ADDR !== 10'd0
        || bb.O_WR_SEL !== 2'd0 || bb.O_TOP_SEL !== 2'd1
        || bb.O_MID_SEL !== 2'd2 || bb.O_WIN_VALID !== 1'b0
        || bb.O_FRAME_START !== 1'b0 || bb.O_LINE_END !== 1'b0
        || bb.O_ERR_OVF !== 1'b0;
  endfunction

  task automatic chk_rst_b(input string t);
    chk({t, ".wr_en"}, bb.O_WR_EN, 0);
    chk({t, ".addr"}, bb.O_ADDR, 0);
    chk({t, ".wr_sel"}, bb.O_WR_SEL, 0);
    chk({t, ".top"}, bb.O_TOP_SEL, 1);
    chk({t, ".mid"}, bb.O_MID_SEL, 2);
    chk({t, ".win"}, bb.O_WIN_VALID, 0);
    chk({t, ".fs"}, bb.O_FRAME_START, 0);
    chk({t, ".le"}, bb.O_LINE_END, 0);
    chk({t, ".ovf"}, bb.O_ERR_OVF, 0);
  endtask

  initial begin
    int wc, ab, sl, wv, wb, ob, rb, ea;
    bit ew, eo;
    string t;

    // 4x4 instance: per-cycle inputs and the outputs after that edge
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0);
    px(1, 0, 0); px(2, 0, 0); px(3, 0, 0); le(1, 0);
    px(0, 1, 0); px(1, 1, 0); px(2, 1, 0); px(3, 1, 0); le(2, 0);
    px(0, 2, 0); px(1, 2, 0); px(2, 2, 1); px(3, 2, 1); le(0, 0);
    px(0, 0, 0); px(1, 0, 0); px(2, 0, 1); px(3, 0, 1); le(1, 0);
    px(0, 1, 0); px(1, 1, 0); px(2, 1, 1); px(3, 1, 1); le(2, 0);
    px(0, 2, 0); px(1, 2, 0); px(2, 2, 1); px(3, 2, 1); le(0, 0);
    px(0, 0, 0); px(1, 0, 0); px(2, 0, 1); px(3, 0, 1);
    if (OVF_ON) add(0, 1, 0, 0, 0, 0, 0, 0, 1);
    else        px(0, 0, 0);
    le(1, OVF_ON);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0);

    db(0, 0);
    sb.I_VSYNC = 1'b0;
    sb.I_DE    = 1'b0;
    repeat (2) cyc();
    chk_rst_b("por");
    rst = 1'b0;
    cyc();
    chk_rst_b("idle");

    db(0, 1);
    repeat (5) cyc();
    chk("idle.no_wr", bb.O_WR_EN, 0);
    db(0, 0);
    cyc();
    chk("idle.no_le", bb.O_LINE_END, 0);

    // nominal frame, 4 lines of 640
    db(1, 0);
    cyc();
    chk("nom.fs", bb.O_FRAME_START, 1);
    db(0, 0);
    cyc();
    chk("nom.fs_once", bb.O_FRAME_START, 0);
    for (int l = 0; l < 4; l++) begin
      wc = 0; ab = 0; sl = 0; wv = 0; wb = 0;
      for (int i = 0; i < 640; i++) begin
        db(0, 1);
        cyc();
        if (bb.O_WR_EN) wc++;
        if (!bb.O_WR_EN || bb.O_ADDR != 10'(i)) ab++;
        if (bb.O_WR_SEL != 2'(l % 3)
            || bb.O_TOP_SEL != 2'((l + 1) % 3)
            || bb.O_MID_SEL != 2'((l + 2) % 3)) sl++;
        if (bb.O_WIN_VALID) wv++;
        if (bb.O_WIN_VALID && (!bb.O_WR_EN || bb.O_ADDR < 10'd2)) wb++;
      end
      t = $sformatf("line%0d", l);
      chk({t, ".wr_cnt"}, wc, 640);
      chk({t, ".addr_seq"}, ab, 0);
      chk({t, ".sel_bad"}, sl, 0);
      chk({t, ".win_cnt"}, wv, (l >= 2) ? 638 : 0);
      chk({t, ".win_pos"}, wb, 0);
      db(0, 0);
      cyc();
      chk({t, ".le"}, bb.O_LINE_END, 1);
      chk({t, ".le_wr"}, bb.O_WR_EN, 0);
      cyc();
      chk({t, ".le_once"}, bb.O_LINE_END, 0);
    end
    chk("rot.sel", bb.O_WR_SEL, 1);

    // overflow: one line of 645
    db(1, 0);
    cyc();
    chk("ovf.fs", bb.O_FRAME_START, 1);
    chk("ovf.sel0", bb.O_WR_SEL, 0);
    wc = 0; ab = 0; ob = 0;
    for (int i = 0; i < 645; i++) begin
      db(0, 1);
      cyc();
      if (OVF_ON) begin
        ew = (i < 640); ea = i; eo = (i >= 640);
      end else begin
        ew = 1'b1; ea = i % 640; eo = 1'b0;
      end
      if (bb.O_WR_EN) wc++;
      if (bb.O_WR_EN != ew || (ew && bb.O_ADDR != 10'(ea))) ab++;
      if (bb.O_ERR_OVF != eo) ob++;
    end
    chk("ovf.wr_cnt", wc, OVF_ON ? 640 : 645);
    chk("ovf.addr_seq", ab, 0);
    chk("ovf.flag_seq", ob, 0);
    db(0, 0);
    cyc();
    chk("ovf.le", bb.O_LINE_END, 1);
    chk("ovf.sticky", bb.O_ERR_OVF, OVF_ON);
    db(1, 0);
    cyc();
    chk("ovf.clr_fs", bb.O_FRAME_START, 1);
    chk("ovf.clr", bb.O_ERR_OVF, 0);

    // frame start coinciding with line end
    db(0, 1);
    repeat (3) cyc();
    db(0, 0);
    cyc();
    chk("sim.sel1", bb.O_WR_SEL, 1);
    db(0, 1);
    repeat (2) cyc();
    db(1, 0);
    cyc();
    chk("sim.fs", bb.O_FRAME_START, 1);
    chk("sim.le", bb.O_LINE_END, 0);
    chk("sim.sel", bb.O_WR_SEL, 0);
    chk("sim.top", bb.O_TOP_SEL, 1);
    chk("sim.mid", bb.O_MID_SEL, 2);

    // frame start coinciding with a pixel
    db(0, 0);
    cyc();
    db(0, 1);
    repeat (3) cyc();
    db(0, 0);
    cyc();
    db(0, 1);
    cyc();
    db(1, 1);
    cyc();
    chk("fsde.fs", bb.O_FRAME_START, 1);
    chk("fsde.wr", bb.O_WR_EN, 1);
    chk("fsde.addr", bb.O_ADDR, 0);
    chk("fsde.sel", bb.O_WR_SEL, 0);
    chk("fsde.win", bb.O_WIN_VALID, 0);
    db(1, 1);
    cyc();
    chk("fsde.addr1", bb.O_ADDR, 1);
    db(0, 1);
    cyc();
    chk("mid.addr2", bb.O_ADDR, 2);

    // reset mid-line, DE held high
    #3 rst = 1'b1;
    #1;
    chk_rst_b("async");
    repeat (2) cyc();
    rst = 1'b0;
    rb = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (rst_bad()) rb++;
    end
    db(0, 0);
    repeat (2) begin
      cyc();
      if (rst_bad()) rb++;
    end
    chk("rst.hold", rb, 0);
    db(1, 1);
    cyc();
    chk("rst.fs", bb.O_FRAME_START, 1);
    chk("rst.wr", bb.O_WR_EN, 1);
    chk("rst.addr", bb.O_ADDR, 0);
    db(0, 0);
    cyc();

    // 4x4 instance vector table
    foreach (tbl[k]) begin
      sb.I_VSYNC = tbl[k].vs;
      sb.I_DE    = tbl[k].de;
      cyc();
      t = $sformatf("v%0d", k);
      chk({t, ".wr"}, sb.O_WR_EN, tbl[k].wr);
      if (tbl[k].wr) chk({t, ".addr"}, sb.O_ADDR, tbl[k].addr);
      chk({t, ".sel"}, sb.O_WR_SEL, tbl[k].sel);
      chk({t, ".top"}, sb.O_TOP_SEL, (tbl[k].sel + 1) % 3);
      chk({t, ".mid"}, sb.O_MID_SEL, (tbl[k].sel + 2) % 3);
      chk({t, ".win"}, sb.O_WIN_VALID, tbl[k].win);
      chk({t, ".fs"}, sb.O_FRAME_START, tbl[k].fs);
      chk({t, ".le"}, sb.O_LINE_END, tbl[k].le);
      chk({t, ".ovf"}, sb.O_ERR_OVF, tbl[k].ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/line_buffer_ctrl.md
LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640: active pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480: active lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 10: line-buffer address width, with 2**ADDR_W >= IMG_WIDTH.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, named as follows.
- I_PCLK  in  1: pixel clock, the only clock.
- I_RST  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have the following ports.
- I_VSYNC  in  1: vertical sync, active-high.
- I_DE  in  1: data enable, one pixel per cycle while high.
- O_WR_EN  out  1: line-buffer write strobe.
- O_WR_SEL  out  2: buffer being written (0..2).
- O_ADDR  out  ADDR_W: write/read column address.
- O_TOP_SEL  out  2: buffer holding row r-2.
- O_MID_SEL  out  2: buffer holding row r-1.
- O_WIN_VALID  out  1: 3x3 window complete this cycle.
- O_FRAME_START  out  1: one-cycle pulse.
- O_LINE_END  out  1: one-cycle pulse.
- O_ERR_OVF  out  1: sticky line-overflow flag.

Function
REQ-006 SHALL register I_VSYNC and I_DE; frame start = VSYNC rising edge; line end = DE falling edge.
REQ-007 SHALL implement FSM IDLE -> FILL on frame start, FILL -> RUN when row count becomes 2, and any state -> FILL on frame start.
REQ-008 SHALL ignore I_DE in IDLE: no writes, no pulses other than O_FRAME_START.
REQ-009 On frame start SHALL clear col, row and wr_sel to 0, clear O_ERR_OVF, and pulse O_FRAME_START one cycle later.
REQ-010 In FILL/RUN with I_DE=1 and col<IMG_WIDTH SHALL drive O_WR_EN=1 and O_ADDR=col on the next cycle, then increment col (latency 1 cycle).
REQ-011 With I_DE=1 and col==IMG_WIDTH SHALL suppress O_WR_EN, hold col, and set O_ERR_OVF until the next frame start.
REQ-012 On line end SHALL pulse O_LINE_END, reset col to 0, advance wr_sel 0->1->2->0, and increment row saturating at IMG_HEIGHT.
REQ-013 SHALL drive O_TOP_SEL=(wr_sel+1) mod 3 and O_MID_SEL=(wr_sel+2) mod 3 at all times.
REQ-014 SHALL assert O_WIN_VALID coincident with O_WR_EN only when state=RUN and the written column >=2.
REQ-015 Rows beyond IMG_HEIGHT SHALL still be written and rotated; the row counter stays saturated.
REQ-016 Frame start and DE=1 in the same cycle: frame start wins, and the pixel is written as column 0 of row 0 of the new frame.
REQ-017 Frame start and line end in the same cycle: frame start wins, and O_LINE_END is not pulsed.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 SHALL, on I_RST=1, asynchronously force state=IDLE and col=row=wr_sel=0.
REQ-020 SHALL, on I_RST=1, asynchronously force O_WR_EN=O_WIN_VALID=O_FRAME_START=O_LINE_END=O_ERR_OVF=0, O_ADDR=0, O_WR_SEL=0, O_TOP_SEL=1, O_MID_SEL=2.
REQ-021 SHALL, after reset mid-line, write nothing until the next VSYNC rising edge.

Configuration
REQ-022 SHALL use macro LBC_OVF_DETECT_EN to gate overflow detection.
- Defined: REQ-011 applies as written.
- Undefined: O_ERR_OVF is tied to 0 and col wraps to 0 after IMG_WIDTH-1, with writes continuing.

Verification
REQ-023 Reset check: pulse I_RST mid-line with DE=1, then release -> all outputs hold reset values and O_WR_EN stays 0 until a VSYNC rising edge.
REQ-024 Nominal frame: one VSYNC, then 3 lines of 640 DE cycles.
- O_WR_EN high 640 cycles per line with O_ADDR 0..639.
- O_WR_SEL goes 0,1,2 across the lines.
- O_WIN_VALID high only on line 3, for O_ADDR 2..639 (638 cycles).
REQ-025 Rotation: 4 lines -> O_WR_SEL=0 on line 4, with O_TOP_SEL=1 and O_MID_SEL=2.
REQ-026 Overflow: one line of 645 DE cycles.
- With LBC_OVF_DETECT_EN: 640 writes, O_ERR_OVF=1 from cycle 641, cleared by the next VSYNC rising edge.
- Without the macro: 645 writes, with O_ADDR wrapping to 0..4.
REQ-027 Simultaneous events: VSYNC rising edge in the same cycle as DE falling -> O_FRAME_START=1, O_LINE_END=0, O_WR_SEL=0.
REQ-028 Saturation: IMG_HEIGHT=4 with 6 lines -> row count saturates at 4 and rotation continues for lines 5 and 6.
